ff_edge_counter: RTL and testbench



---
 rtl/ff_counter_pkg.sv | 9 +
 rtl/rising_edge_detect.sv | 24 ++
 rtl/ff_edge_counter.sv | 82 ++++++++
 tb/tb_ff_edge_counter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_counter_pkg.sv
// Shared constants for the flip-flop and counter stage.
package ff_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_MODULUS = 10;

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector for a signal already in the clock domain.
// The history register resets to 1 so a level that is already high when reset
// releases is not reported as an edge.
module rising_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic edge_out
);

  logic q_hist;

  // Track the previous sample every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_hist <= 1'b1;
    end else begin
      q_hist <= sig_in;
    end
  end

  assign edge_out = sig_in & ~q_hist;

endmodule

// File: rtl/ff_edge_counter.sv
// Counts rising edges of the upstream flip-flop output modulo MODULUS.
// Supports up/down counting, synchronous load with clamping, a terminal-count
// pulse on wrap and a sticky overflow flag.
module ff_edge_counter
  import ff_counter_pkg::*;
#(
  parameter  int MODULUS = DEF_MODULUS,
  localparam int W       = $clog2(MODULUS)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         q_in,
  input  logic         enable,
  input  logic         up_down,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         clear_ovf,
  output logic [W-1:0] count,
  output logic         edge_pulse,
  output logic         tc_pulse,
  output logic         ovf_flag
);

  localparam logic [W-1:0] MAX_CNT = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MODULUS);

  logic         q_edge;
  logic [W-1:0] count_nxt;
  logic         wrap;

  rising_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .sig_in   (q_in),
    .edge_out (q_edge)
  );

  // Next count and wrap detection; load overrides and drops a coincident edge.
  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    if (load) begin
      if ({1'b0, load_value} >= MOD_EXT) begin
        count_nxt = MAX_CNT;
      end else begin
        count_nxt = load_value;
      end
    end else if (enable && q_edge) begin
      if (up_down == DIR_UP) begin
        if (count == MAX_CNT) begin
          count_nxt = '0;
          wrap      = 1'b1;
        end else begin
          count_nxt = count + W'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = MAX_CNT;
          wrap      = 1'b1;
        end else begin
          count_nxt = count - W'(1);
        end
      end
    end
  end

  // Registered count, pulses and sticky flag; a wrap beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      edge_pulse <= 1'b0;
      tc_pulse   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      count      <= count_nxt;
      edge_pulse <= q_edge;
      tc_pulse   <= wrap;
      ovf_flag   <= wrap | (ovf_flag & ~clear_ovf);
    end
  end

endmodule

// File: tb/tb_ff_edge_counter.sv
// Self-checking bench for ff_edge_counter with a behavioural reference model.
module tb_ff_edge_counter;

  localparam int MOD = 10;
  localparam int W   = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         q_in;
  logic         enable;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_value;
  logic         clear_ovf;
  logic [W-1:0] count;
  logic         edge_pulse;
  logic         tc_pulse;
  logic         ovf_flag;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_count;
  bit m_prev;
  bit m_edge;
  bit m_tc;
  bit m_ovf;

  ff_edge_counter #(.MODULUS(MOD)) dut (
    .clock      (clock),
    .reset      (reset),
    .q_in       (q_in),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .clear_ovf  (clear_ovf),
    .count      (count),
    .edge_pulse (edge_pulse),
    .tc_pulse   (tc_pulse),
    .ovf_flag   (ovf_flag)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    int  nxt;
    bit  e;
    if (reset) begin
      m_count = 0; m_edge = 0; m_tc = 0; m_ovf = 0; m_prev = 1;
    end else begin
      e      = q_in && !m_prev;
      m_prev = q_in;
      m_edge = e;
      m_tc   = 0;
      if (load) begin
        m_count = (int'(load_value) >= MOD) ? MOD - 1 : int'(load_value);
      end else if (enable && e) begin
        nxt = up_down ? m_count + 1 : m_count - 1;
        if (nxt < 0 || nxt >= MOD) m_tc = 1;
        m_count = (nxt + MOD) % MOD;
      end
      if (m_tc) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  endtask

  // Inputs are driven at the falling edge; one rising edge; sample at next falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; q_in = 0; enable = 0; up_down = 1; load = 0;
    load_value = '0; clear_ovf = 0;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1; q_in = 1;
    tick(); tick();
    checks++;
    if (count !== 4'd0 || edge_pulse !== 1'b0 || tc_pulse !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: count=%0d edge=%b tc=%b ovf=%b, required all 0",
               count, edge_pulse, tc_pulse, ovf_flag);
    end
    reset = 0; enable = 1; up_down = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || edge_pulse !== 1'b0) begin
        errors++;
        $display("FAIL held_high_after_reset: cycle %0d count=%0d edge=%b, required 0/0",
                 i, count, edge_pulse);
      end
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      q_in = 0; tick();
      checks++;
      if (edge_pulse !== 1'b0) begin
        errors++;
        $display("FAIL edge_low_phase: edge=%b, required 0", edge_pulse);
      end
      q_in = 1; tick();
      if (edge_pulse === 1'b1) pulses++;
    end
    checks++;
    if (count !== 4'd3 || pulses != 3 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL three_edges: count=%0d pulses=%0d tc=%b, required 3/3/0",
               count, pulses, tc_pulse);
    end
  endtask

  task automatic test_wrap_up();
    q_in = 0; load = 1; load_value = 4'd8; tick();
    load = 0;
    q_in = 1; tick();
    checks++;
    if (count !== 4'd9 || tc_pulse !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL up_to_9: count=%0d tc=%b ovf=%b, required 9/0/0", count, tc_pulse, ovf_flag);
    end
    q_in = 0; tick();
    q_in = 1; tick();
    checks++;
    if (count !== 4'd0 || tc_pulse !== 1'b1 || ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: count=%0d tc=%b ovf=%b, required 0/1/1", count, tc_pulse, ovf_flag);
    end
    q_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tc_pulse !== 1'b0 || ovf_flag !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky: tc=%b ovf=%b, required 0/1", tc_pulse, ovf_flag);
      end
    end
    clear_ovf = 1; tick(); clear_ovf = 0;
    checks++;
    if (ovf_flag !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b count=%0d, required 0/0", ovf_flag, count);
    end
  endtask

  task automatic test_wrap_down();
    up_down = 0; q_in = 1; tick();
    checks++;
    if (count !== 4'd9 || tc_pulse !== 1'b1 || ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: count=%0d tc=%b ovf=%b, required 9/1/1", count, tc_pulse, ovf_flag);
    end
    q_in = 0; load = 1; load_value = 4'd0; tick(); load = 0;
    q_in = 1; clear_ovf = 1; tick(); clear_ovf = 0;
    checks++;
    if (count !== 4'd9 || tc_pulse !== 1'b1 || ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL wrap_beats_clear: count=%0d tc=%b ovf=%b, required 9/1/1",
               count, tc_pulse, ovf_flag);
    end
    q_in = 0; tick();
    checks++;
    if (tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tc_single_cycle: tc=%b, required 0", tc_pulse);
    end
    up_down = 1;
  endtask

  task automatic test_load_edge();
    q_in = 0; tick();
    load = 1; load_value = 4'd4; q_in = 1; tick();
    checks++;
    if (count !== 4'd4 || edge_pulse !== 1'b1 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL load_with_edge: count=%0d edge=%b tc=%b, required 4/1/0",
               count, edge_pulse, tc_pulse);
    end
    q_in = 0; load_value = 4'd15; tick(); load = 0;
    checks++;
    if (count !== 4'd9) begin
      errors++;
      $display("FAIL load_clamp: count=%0d, required 9", count);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] held;
    held = count;
    enable = 0; q_in = 0; tick();
    q_in = 1; tick();
    checks++;
    if (count !== held || edge_pulse !== 1'b1) begin
      errors++;
      $display("FAIL disabled_rise: count=%0d edge=%b, required %0d/1", count, edge_pulse, held);
    end
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== held || edge_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reenable_high: count=%0d edge=%b, required %0d/0", count, edge_pulse, held);
      end
    end
  endtask

  task automatic test_reset_mid();
    q_in = 0; load = 1; load_value = 4'd6; tick(); load = 0;
    checks++;
    if (count !== 4'd6) begin
      errors++;
      $display("FAIL preload_6: count=%0d, required 6", count);
    end
    reset = 1; q_in = 1; tick(); reset = 0;
    checks++;
    if (count !== 4'd0 || edge_pulse !== 1'b0 || tc_pulse !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d edge=%b tc=%b ovf=%b, required all 0",
               count, edge_pulse, tc_pulse, ovf_flag);
    end
    q_in = 0; tick();
    q_in = 1; tick();
    checks++;
    if (count !== 4'd1 || edge_pulse !== 1'b1) begin
      errors++;
      $display("FAIL count_after_reset: count=%0d edge=%b, required 1/1", count, edge_pulse);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      q_in       = $urandom_range(0, 1);
      enable     = ($urandom_range(0, 4) != 0);
      up_down    = $urandom_range(0, 1);
      load       = ($urandom_range(0, 9) == 0);
      load_value = W'($urandom_range(0, 15));
      clear_ovf  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (count !== W'(m_count) || edge_pulse !== m_edge ||
          tc_pulse !== m_tc || ovf_flag !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d: count=%0d edge=%b tc=%b ovf=%b, required %0d/%b/%b/%b",
                 i, count, edge_pulse, tc_pulse, ovf_flag, m_count, m_edge, m_tc, m_ovf);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clock);
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_edge();
    test_enable();
    test_reset_mid();
    idle_inputs();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
